// File: rtl/gf_pkg.sv
// GF(2^8) arithmetic shared by the Reed-Solomon decoder stages, plus the
// types used by the Forney error-magnitude block (rs_forney).
// Field: primitive polynomial x^8+x^4+x^3+x^2+1, alpha = 0x02.
package gf_pkg;

  localparam int SYMB_WIDTH  = 8;
  localparam int SYMB_NUM    = 1 << SYMB_WIDTH;
  localparam int T_LEN       = 4;
  localparam int FCR_DEFAULT = 1;

  // Reduction term applied when a shift overflows bit SYMB_WIDTH-1.
  localparam logic [SYMB_WIDTH-1:0] GF_POLY_LOW = 8'h1D;

  typedef logic [SYMB_WIDTH-1:0]             symb_t;
  typedef logic [SYMB_WIDTH:0]               gf_exp_t;
  typedef logic [T_LEN:0][SYMB_WIDTH-1:0]    lambda_t;
  typedef logic [T_LEN-1:0][SYMB_WIDTH-1:0]  symb_vec_t;

  typedef enum logic [1:0] {IDLE, WAIT_POS, EVAL, DONE} forney_state_t;

  // Shift-and-add multiply with modular reduction.
  function automatic symb_t gf_mult(input symb_t a, input symb_t b);
    symb_t p, s;
    p = '0;
    s = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) p = p ^ s;
      s = s[SYMB_WIDTH-1] ? ((s << 1) ^ GF_POLY_LOW) : (s << 1);
    end
    return p;
  endfunction

  // Square-and-multiply exponentiation.
  function automatic symb_t gf_pow(input symb_t a, input gf_exp_t e);
    symb_t r, b;
    r = symb_t'(1);
    b = a;
    for (int i = 0; i <= SYMB_WIDTH; i++) begin
      if (e[i]) r = gf_mult(r, b);
      b = gf_mult(b, b);
    end
    return r;
  endfunction

  function automatic symb_t gf_alpha_to_symb(input gf_exp_t e);
    return gf_pow(symb_t'(2), e);
  endfunction

  // a^(q-2) is the inverse for nonzero a; 0 maps to 0.
  function automatic symb_t gf_inv(input symb_t a);
    return gf_pow(a, gf_exp_t'(SYMB_NUM - 2));
  endfunction

  // Exponent of X^-1 for a symbol position: (q-1-pos) mod (q-1).
  function automatic gf_exp_t gf_pos_inv_exp(input symb_t pos);
    gf_exp_t e;
    e = gf_exp_t'(SYMB_NUM - 1) - {1'b0, pos};
    if (e >= gf_exp_t'(SYMB_NUM - 1)) e = e - gf_exp_t'(SYMB_NUM - 1);
    return e;
  endfunction

  // Formal derivative in characteristic 2: even-index coefficients vanish.
  // Result d[k] = lambda[k+1] for odd k+1, so evaluating d gives Lambda'(x).
  function automatic symb_vec_t gf_poly_deriv_odd(input lambda_t lam);
    symb_vec_t d;
    for (int k = 0; k < T_LEN; k++) d[k] = (k % 2 == 0) ? lam[k+1] : '0;
    return d;
  endfunction

endpackage

// File: rtl/rs_forney_if.sv
// Error-magnitude output stream: (position, value) beats to the corrector.
interface rs_forney_if;
  import gf_pkg::*;

  symb_t err_pos;
  symb_t err_val;
  logic  err_vld;
  logic  err_last;
  logic  err_rdy;

  modport master (output err_pos, err_val, err_vld, err_last, input err_rdy);
  modport slave  (input err_pos, err_val, err_vld, err_last, output err_rdy);
endinterface

// File: rtl/rs_forney_eval.sv
// Horner evaluation of an N-coefficient GF polynomial at symbol x
// (coef[0] is the constant term).
module rs_forney_eval
  import gf_pkg::*;
#(
  parameter int N = T_LEN
) (
  input  logic [N-1:0][SYMB_WIDTH-1:0] coef,
  input  symb_t                        x,
  output symb_t                        y
);

  // Highest coefficient first: y = (..(c[N-1]*x + c[N-2])*x ..) + c[0].
  always_comb begin
    y = '0;
    for (int i = N - 1; i >= 0; i--) y = gf_mult(y, x) ^ coef[i];
  end

endmodule

// File: rtl/rs_forney.sv
// Reed-Solomon Forney stage: captures Lambda/Omega, then the Chien positions,
// and streams error magnitudes e_j = Omega(Xj^-1) / Lambda'(Xj^-1)
// (times Xj when FCR=0) as (pos, val) beats.
// Optional: RS_FORNEY_ROOT_CHECK_EN also checks Lambda(Xj^-1)==0 per position
// and flags the block as failed otherwise.
module rs_forney
  import gf_pkg::*;
#(
  parameter int FCR       = FCR_DEFAULT,
  parameter int EVAL_PIPE = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  lambda_t     error_locator,
  input  symb_vec_t   error_evaluator,
  input  logic        error_locator_vld,
  input  symb_vec_t   error_positions,
  input  logic        error_positions_vld,
  input  logic        rs_chien_err,
  rs_forney_if.master err_if,
  output logic        forney_done,
  output logic        forney_fail
);

  localparam int STAGES = 2 + EVAL_PIPE;
  localparam int IDXW   = $clog2(T_LEN + 1);

  forney_state_t   state, state_n;
  lambda_t         lam_r;
  symb_vec_t       omg_r, pos_r;
  logic [IDXW-1:0] nerr_c, nerr_r, idx;
  logic            fail_r;
  logic [STAGES:1] vld_pipe;
  logic            issue_vld, advance, last_xfer, take_pos, early_exit;
  symb_t           pos_sel;
  symb_t           s1_pos, s1_xinv;
  logic            s1_last;
  symb_t           num_c, den_c;
  logic            root_bad_c;
  symb_t           e_pos, e_num, e_den, e_val;
  logic            e_last, e_root_bad, e_vld;
  symb_t           out_pos, out_val;
  logic            out_last;

  // Degree of Lambda = number of errors to process.
  always_comb begin
    nerr_c = '0;
    for (int i = 1; i <= T_LEN; i++)
      if (error_locator[i] != '0) nerr_c = IDXW'(i);
  end

  assign take_pos   = (state == WAIT_POS) && error_positions_vld && !error_locator_vld;
  assign early_exit = rs_chien_err || (lam_r[0] == '0) || (nerr_r == '0);
  assign advance    = !vld_pipe[STAGES] || err_if.err_rdy;
  assign last_xfer  = vld_pipe[STAGES] && err_if.err_rdy && out_last;
  assign issue_vld  = (state == EVAL) && (idx < nerr_r);

  // State register.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else          state <= state_n;

  // Next state; a new polynomial pair aborts whatever block is in flight.
  always_comb begin
    state_n = state;
    if (error_locator_vld) state_n = WAIT_POS;
    else begin
      case (state)
        IDLE:     state_n = IDLE;
        WAIT_POS: if (error_positions_vld) state_n = early_exit ? DONE : EVAL;
        EVAL:     if (last_xfer) state_n = DONE;
        DONE:     state_n = IDLE;
        default:  state_n = IDLE;
      endcase
    end
  end

  // Polynomial capture and position capture.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      lam_r  <= '0;
      omg_r  <= '0;
      nerr_r <= '0;
      pos_r  <= '0;
    end else begin
      if (error_locator_vld) begin
        lam_r  <= error_locator;
        omg_r  <= error_evaluator;
        nerr_r <= nerr_c;
      end
      if (take_pos) pos_r <= error_positions;
    end

  // Block failure flag: set at position capture or by any bad beat, sticky.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn)                fail_r <= 1'b0;
    else if (error_locator_vld)  fail_r <= 1'b0;
    else if (take_pos)           fail_r <= rs_chien_err || (lam_r[0] == '0);
    else if (advance && e_vld && (e_den == '0 || e_root_bad)) fail_r <= 1'b1;

  // Position index issue counter.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn)                                  idx <= '0;
    else if (error_locator_vld || state != EVAL)   idx <= '0;
    else if (issue_vld && advance)                 idx <= idx + IDXW'(1);

  always_comb begin
    pos_sel = '0;
    for (int i = 0; i < T_LEN; i++)
      if (idx == IDXW'(i)) pos_sel = pos_r[i];
  end

  // Valid shift register; the whole pipe stalls while the output is held.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn)               vld_pipe <= '0;
    else if (error_locator_vld) vld_pipe <= '0;
    else if (advance)           vld_pipe <= {vld_pipe[STAGES-1:1], issue_vld};

  // Stage 1: position -> X^-1.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      s1_pos  <= '0;
      s1_xinv <= '0;
      s1_last <= 1'b0;
    end else if (advance) begin
      s1_pos  <= pos_sel;
      s1_xinv <= gf_alpha_to_symb(gf_pos_inv_exp(pos_sel));
      s1_last <= (idx == nerr_r - IDXW'(1));
    end

  rs_forney_eval #(.N(T_LEN)) u_num_eval (
    .coef (omg_r),
    .x    (s1_xinv),
    .y    (num_c)
  );

  rs_forney_eval #(.N(T_LEN)) u_den_eval (
    .coef (gf_poly_deriv_odd(lam_r)),
    .x    (s1_xinv),
    .y    (den_c)
  );

`ifdef RS_FORNEY_ROOT_CHECK_EN
  symb_t lam_c;

  rs_forney_eval #(.N(T_LEN + 1)) u_lam_eval (
    .coef (lam_r),
    .x    (s1_xinv),
    .y    (lam_c)
  );

  assign root_bad_c = (lam_c != '0);
`else
  assign root_bad_c = 1'b0;
`endif

  generate
    if (EVAL_PIPE != 0) begin : g_eval_reg
      // Stage 2: registered evaluation results.
      always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
          e_pos      <= '0;
          e_num      <= '0;
          e_den      <= '0;
          e_last     <= 1'b0;
          e_root_bad <= 1'b0;
        end else if (advance) begin
          e_pos      <= s1_pos;
          e_num      <= num_c;
          e_den      <= den_c;
          e_last     <= s1_last;
          e_root_bad <= root_bad_c;
        end
    end else begin : g_eval_comb
      assign e_pos      = s1_pos;
      assign e_num      = num_c;
      assign e_den      = den_c;
      assign e_last     = s1_last;
      assign e_root_bad = root_bad_c;
    end
  endgenerate

  assign e_vld = vld_pipe[STAGES-1];

  // Forney division; a zero derivative yields a zero magnitude.
  always_comb begin
    e_val = '0;
    if (e_den != '0) begin
      e_val = gf_mult(e_num, gf_inv(e_den));
      if (FCR == 0) e_val = gf_mult(e_val, gf_alpha_to_symb({1'b0, e_pos}));
    end
  end

  // Output register; empty slots load zeros so idle outputs read 0.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      out_pos  <= '0;
      out_val  <= '0;
      out_last <= 1'b0;
    end else if (error_locator_vld) begin
      out_pos  <= '0;
      out_val  <= '0;
      out_last <= 1'b0;
    end else if (advance) begin
      out_pos  <= e_vld ? e_pos : '0;
      out_val  <= e_vld ? e_val : '0;
      out_last <= e_vld && e_last;
    end

  assign err_if.err_pos  = out_pos;
  assign err_if.err_val  = out_val;
  assign err_if.err_last = out_last;
  assign err_if.err_vld  = vld_pipe[STAGES];

  // A recapture in DONE aborts the block, so its done pulse is suppressed.
  assign forney_done = (state == DONE) && !error_locator_vld;
  assign forney_fail = forney_done && fail_r;

endmodule

// File: tb/tb_rs_forney.sv
// Self-checking bench for rs_forney: errors are chosen first, Lambda/Omega are
// built from them with log/antilog field arithmetic, and the stream must give
// back exactly the chosen positions and magnitudes.
module tb_rs_forney;
  import gf_pkg::*;

  logic      aclk = 1'b0;
  logic      aresetn;
  lambda_t   error_locator;
  symb_vec_t error_evaluator, error_positions;
  logic      error_locator_vld, error_positions_vld, rs_chien_err;
  logic      forney_done, forney_fail;

  rs_forney_if eif ();

  rs_forney dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .error_locator       (error_locator),
    .error_evaluator     (error_evaluator),
    .error_locator_vld   (error_locator_vld),
    .error_positions     (error_positions),
    .error_positions_vld (error_positions_vld),
    .rs_chien_err        (rs_chien_err),
    .err_if              (eif),
    .forney_done         (forney_done),
    .forney_fail         (forney_fail)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int gexp [0:254];
  int glog [0:255];

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  // Lambda = prod(1 + Xj x); Omega = sum_j ej*Xj*prod_{k!=j}(1 + Xk x)  (FCR=1).
  function automatic void build_polys(input int n, input int p[T_LEN], input int m[T_LEN],
                                      output lambda_t l, output symb_vec_t o);
    int lam[T_LEN+1];
    int om[T_LEN+1];
    int term[T_LEN+1];
    int x[T_LEN];
    for (int i = 0; i <= T_LEN; i++) begin lam[i] = 0; om[i] = 0; end
    lam[0] = 1;
    for (int j = 0; j < n; j++) x[j] = gexp[p[j]];
    for (int j = 0; j < n; j++)
      for (int i = T_LEN; i >= 1; i--) lam[i] ^= gmul(x[j], lam[i-1]);
    for (int j = 0; j < n; j++) begin
      for (int i = 0; i <= T_LEN; i++) term[i] = 0;
      term[0] = gmul(m[j], x[j]);
      for (int k = 0; k < n; k++)
        if (k != j)
          for (int i = T_LEN; i >= 1; i--) term[i] ^= gmul(x[k], term[i-1]);
      for (int i = 0; i <= T_LEN; i++) om[i] ^= term[i];
    end
    for (int i = 0; i <= T_LEN; i++) l[i] = symb_t'(lam[i]);
    for (int i = 0; i < T_LEN; i++) o[i] = symb_t'(om[i]);
  endfunction

  // Runs one block (optionally sending polynomials first) and compares the
  // beat stream, stall stability, done timing and the fail flag.
  task automatic check_block(input string name, input lambda_t l, input symb_vec_t o,
                             input symb_vec_t posv, input bit chien, input int exp_n,
                             input symb_vec_t exp_val, input bit exp_fail, input int mode,
                             input bit send_polys);
    int nb, done_c, last_c, unstable;
    bit got_done, got_fail, prev_stall, rdy;
    symb_t ppos, pval;
    bit plast;
    symb_t bpos[$];
    symb_t bval[$];
    bit blast[$];
    nb = 0; done_c = -1; last_c = -1; unstable = 0;
    got_done = 0; got_fail = 0; prev_stall = 0; ppos = '0; pval = '0; plast = 0;
    if (send_polys) begin
      @(negedge aclk);
      error_locator = l; error_evaluator = o; error_locator_vld = 1'b1;
    end
    @(negedge aclk);
    error_locator_vld = 1'b0;
    error_positions = posv; rs_chien_err = chien; error_positions_vld = 1'b1;
    for (int c = 0; c < 200 && !got_done; c++) begin
      @(negedge aclk);
      error_positions_vld = 1'b0; rs_chien_err = 1'b0;
      if (prev_stall && !(eif.err_vld === 1'b1 && eif.err_pos === ppos &&
                          eif.err_val === pval && eif.err_last === plast)) unstable++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      eif.err_rdy = rdy;
      if (forney_done === 1'b1) begin got_done = 1; got_fail = forney_fail; done_c = c; end
      if (eif.err_vld === 1'b1 && rdy) begin
        bpos.push_back(eif.err_pos); bval.push_back(eif.err_val); blast.push_back(eif.err_last);
        nb++; last_c = c;
      end
      prev_stall = (eif.err_vld === 1'b1) && !rdy;
      ppos = eif.err_pos; pval = eif.err_val; plast = eif.err_last;
    end
    eif.err_rdy = 1'b1;

    checks++;
    if (!got_done) begin
      errors++; $display("FAIL %s done_timeout got no forney_done within 200 cycles", name);
    end
    checks++;
    if (nb !== exp_n) begin
      errors++; $display("FAIL %s beat_count got %0d want %0d", name, nb, exp_n);
    end
    for (int i = 0; i < nb && i < exp_n; i++) begin
      checks++;
      if (bpos[i] !== posv[i] || bval[i] !== exp_val[i] || blast[i] !== (i == exp_n - 1)) begin
        errors++;
        $display("FAIL %s beat%0d got pos=%0d val=%02h last=%0b want pos=%0d val=%02h last=%0b",
                 name, i, bpos[i], bval[i], blast[i], posv[i], exp_val[i], (i == exp_n - 1));
      end
    end
    checks++;
    if (unstable !== 0) begin
      errors++; $display("FAIL %s stall_stability got %0d changes want 0", name, unstable);
    end
    checks++;
    if (got_done && done_c !== ((exp_n > 0) ? last_c + 1 : 0)) begin
      errors++; $display("FAIL %s done_cycle got %0d want %0d", name, done_c,
                         (exp_n > 0) ? last_c + 1 : 0);
    end
    checks++;
    if (got_done && got_fail !== exp_fail) begin
      errors++; $display("FAIL %s forney_fail got %0b want %0b", name, got_fail, exp_fail);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    checks++;
    if ({eif.err_vld, eif.err_pos, eif.err_val, eif.err_last, forney_done, forney_fail} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got vld=%0b pos=%0d val=%02h last=%0b done=%0b fail=%0b want all 0",
               eif.err_vld, eif.err_pos, eif.err_val, eif.err_last, forney_done, forney_fail);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if ({eif.err_vld, forney_done} !== 2'b00) begin
      errors++; $display("FAIL reset_release got vld=%0b done=%0b want 0 0", eif.err_vld, forney_done);
    end
  endtask

  task automatic test_ignore_pos_idle();
    bit seen;
    seen = 0;
    @(negedge aclk);
    error_positions = '0; error_positions_vld = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      error_positions_vld = 1'b0;
      seen |= (eif.err_vld === 1'b1) || (forney_done === 1'b1);
    end
    checks++;
    if (seen) begin errors++; $display("FAIL idle_pos_ignored got activity=1 want 0"); end
  endtask

  task automatic test_single();
    int p[T_LEN] = '{5, 0, 0, 0};
    int m[T_LEN] = '{8'h3A, 0, 0, 0};
    lambda_t l; symb_vec_t o, posv, ev;
    build_polys(1, p, m, l, o);
    posv = '0; posv[0] = 8'd5; ev = '0; ev[0] = 8'h3A;
    check_block("single", l, o, posv, 1'b0, 1, ev, 1'b0, 0, 1'b1);
  endtask

  task automatic test_three_stall();
    int p[T_LEN] = '{3, 17, 200, 0};
    int m[T_LEN] = '{8'h01, 8'h80, 8'hFF, 0};
    lambda_t l; symb_vec_t o, posv, ev;
    build_polys(3, p, m, l, o);
    posv = '0; ev = '0;
    for (int i = 0; i < 3; i++) begin posv[i] = symb_t'(p[i]); ev[i] = symb_t'(m[i]); end
    check_block("three_stall", l, o, posv, 1'b0, 3, ev, 1'b0, 1, 1'b1);
  endtask

  task automatic test_early_exits();
    int p[T_LEN] = '{9, 40, 0, 0};
    int m[T_LEN] = '{8'h11, 8'h22, 0, 0};
    lambda_t l; symb_vec_t o, posv, ev;
    build_polys(2, p, m, l, o);
    posv = '0; posv[0] = 8'd9; posv[1] = 8'd40; ev = '0;
    check_block("chien_err", l, o, posv, 1'b1, 0, ev, 1'b1, 0, 1'b1);
    l = '0; l[0] = 8'h01;
    check_block("nerr_zero", l, o, posv, 1'b0, 0, ev, 1'b0, 0, 1'b1);
    l = '0; l[1] = 8'h01;
    check_block("lambda0_zero", l, o, posv, 1'b0, 0, ev, 1'b1, 0, 1'b1);
  endtask

  // Lambda with no odd terms has Lambda' == 0 everywhere.
  task automatic test_den_zero();
    lambda_t l; symb_vec_t o, posv, ev;
    l = '0; l[0] = 8'h01; l[2] = 8'h55;
    o = '0; o[0] = 8'h9C; o[1] = 8'h13;
    posv = '0; posv[0] = 8'd10; posv[1] = 8'd20; ev = '0;
    check_block("den_zero", l, o, posv, 1'b0, 2, ev, 1'b1, 0, 1'b1);
  endtask

  task automatic test_abort();
    int pa[T_LEN] = '{30, 60, 90, 0};
    int ma[T_LEN] = '{8'h05, 8'h06, 8'h07, 0};
    int pb[T_LEN] = '{100, 254, 0, 0};
    int mb[T_LEN] = '{8'hC3, 8'h3C, 0, 0};
    lambda_t la, lb; symb_vec_t oa, ob, posv, ev;
    int cnt; bit hit, seen;
    build_polys(3, pa, ma, la, oa);
    build_polys(2, pb, mb, lb, ob);
    cnt = 0; hit = 0; seen = 0;
    @(negedge aclk);
    error_locator = la; error_evaluator = oa; error_locator_vld = 1'b1;
    @(negedge aclk);
    error_locator_vld = 1'b0;
    posv = '0; for (int i = 0; i < 3; i++) posv[i] = symb_t'(pa[i]);
    error_positions = posv; error_positions_vld = 1'b1;
    eif.err_rdy = 1'b1;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge aclk);
      error_positions_vld = 1'b0;
      if (eif.err_vld === 1'b1) cnt++;
      if (cnt == 2) begin
        hit = 1;
        error_locator = lb; error_evaluator = ob; error_locator_vld = 1'b1;
      end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL abort_reach got %0d beats want 2 before abort", cnt); end
    @(negedge aclk);
    error_locator_vld = 1'b0;
    checks++;
    if (eif.err_vld !== 1'b0) begin
      errors++; $display("FAIL abort_vld_drop got err_vld=%0b want 0", eif.err_vld);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      seen |= (eif.err_vld === 1'b1) || (forney_done === 1'b1);
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_quiet got activity=1 want 0"); end
    posv = '0; ev = '0;
    for (int i = 0; i < 2; i++) begin posv[i] = symb_t'(pb[i]); ev[i] = symb_t'(mb[i]); end
    check_block("after_abort", lb, ob, posv, 1'b0, 2, ev, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int p[T_LEN] = '{1, 2, 3, 0};
    int m[T_LEN] = '{8'hAA, 8'hBB, 8'hCC, 0};
    lambda_t l; symb_vec_t o, posv;
    build_polys(3, p, m, l, o);
    posv = '0; for (int i = 0; i < 3; i++) posv[i] = symb_t'(p[i]);
    eif.err_rdy = 1'b0;
    @(negedge aclk);
    error_locator = l; error_evaluator = o; error_locator_vld = 1'b1;
    @(negedge aclk);
    error_locator_vld = 1'b0; error_positions = posv; error_positions_vld = 1'b1;
    @(negedge aclk);
    error_positions_vld = 1'b0;
    repeat (5) @(negedge aclk);
    checks++;
    if (eif.err_vld !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre got err_vld=%0b want 1", eif.err_vld);
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if ({eif.err_vld, eif.err_pos, eif.err_val, eif.err_last, forney_done, forney_fail} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got vld=%0b pos=%0d val=%02h last=%0b want all 0",
               eif.err_vld, eif.err_pos, eif.err_val, eif.err_last);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    eif.err_rdy = 1'b1;
    test_single();
  endtask

  task automatic test_random();
    int p[T_LEN];
    int m[T_LEN];
    int n;
    bit dup;
    lambda_t l; symb_vec_t o, posv, ev;
    for (int b = 0; b < 8; b++) begin
      n = $urandom_range(1, T_LEN);
      for (int j = 0; j < T_LEN; j++) begin p[j] = 0; m[j] = 0; end
      for (int j = 0; j < n; j++) begin
        do begin
          p[j] = $urandom_range(0, 254);
          dup = 0;
          for (int k = 0; k < j; k++) if (p[k] == p[j]) dup = 1;
        end while (dup);
        m[j] = $urandom_range(1, 255);
      end
      build_polys(n, p, m, l, o);
      ev = '0;
      for (int j = 0; j < T_LEN; j++)
        posv[j] = (j < n) ? symb_t'(p[j]) : symb_t'($urandom_range(0, 255));
      for (int j = 0; j < n; j++) ev[j] = symb_t'(m[j]);
      check_block($sformatf("random%0d", b), l, o, posv, 1'b0, n, ev, 1'b0, 2, 1'b1);
    end
  endtask

  // Position 6 is not a root of Lambda built for an error at 5.
  task automatic test_root_check();
    int p[T_LEN] = '{5, 0, 0, 0};
    int m[T_LEN] = '{8'h3A, 0, 0, 0};
    lambda_t l; symb_vec_t o, posv, ev;
    bit exp_fail;
`ifdef RS_FORNEY_ROOT_CHECK_EN
    exp_fail = 1'b1;
`else
    exp_fail = 1'b0;
`endif
    build_polys(1, p, m, l, o);
    posv = '0; posv[0] = 8'd6; ev = '0; ev[0] = 8'h3A;
    check_block("root_check", l, o, posv, 1'b0, 1, ev, exp_fail, 0, 1'b1);
  endtask

  initial begin
    int v;
    v = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = v; glog[v] = i;
      v = v << 1;
      if (v & 256) v = v ^ 'h11D;
    end
    glog[0] = 0;
    aresetn = 1'b0;
    error_locator = '0; error_evaluator = '0; error_positions = '0;
    error_locator_vld = 1'b0; error_positions_vld = 1'b0; rs_chien_err = 1'b0;
    eif.err_rdy = 1'b1;

    test_reset();
    test_ignore_pos_idle();
    test_single();
    test_three_stall();
    test_early_exits();
    test_den_zero();
    test_abort();
    test_reset_mid();
    test_random();
    test_root_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_forney.md
Name: rs_forney

Overview:
- Reed-Solomon error-magnitude stage, directly downstream of the Chien search block.
- Captures the error-locator Lambda(x) and error-evaluator Omega(x) polynomials when they are issued.
- Later captures the Chien error positions and computes each magnitude with Forney's formula.
- Streams (position, value) pairs to the codeword corrector under a valid/ready handshake.

Parameters:
- FCR, 1: first consecutive root of the generator polynomial; must be 0 or 1.
- EVAL_PIPE, 1: 1 = register the polynomial-evaluation results (3-cycle pipe); 0 = combinational (2-cycle pipe).
- SYMB_WIDTH, T_LEN, SYMB_NUM: taken from gf_pkg, not module parameters.

Ports:
- aclk in 1: clock.
- aresetn in 1: asynchronous active-low reset.
- error_locator in [SYMB_WIDTH-1:0] x [T_LEN:0]: Lambda coefficients; index 0 is the constant term.
- error_evaluator in [SYMB_WIDTH-1:0] x [T_LEN-1:0]: Omega coefficients.
- error_locator_vld in 1: one-cycle pulse; both polynomials are valid.
- error_positions in [SYMB_WIDTH-1:0] x [T_LEN-1:0]: Chien positions.
- error_positions_vld in 1: one-cycle pulse; positions are valid.
- rs_chien_err in 1: Chien failure flag, sampled with error_positions_vld.
- err_pos out SYMB_WIDTH: symbol position of the current error.
- err_val out SYMB_WIDTH: error magnitude.
- err_vld out 1: output beat valid.
- err_last out 1: marks the final beat of a block.
- err_rdy in 1: downstream ready.
- forney_done out 1: one-cycle pulse at block completion.
- forney_fail out 1: qualified by forney_done; block is uncorrectable.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; captured registers cleared.
- Capture on error_locator_vld:
  - Register Lambda and Omega.
  - nerr = index of the highest nonzero Lambda coefficient in 1..T_LEN; 0 if none.
- FSM IDLE -> WAIT_POS on error_locator_vld.
- FSM WAIT_POS -> EVAL on error_positions_vld:
  - Register positions and rs_chien_err.
  - Only entries 0..nerr-1 are meaningful.
- Exit from WAIT_POS straight to DONE, skipping EVAL, in three cases:
  - rs_chien_err=1: fail=1.
  - Lambda[0]==0: fail=1.
  - nerr==0: fail=0; done with no beats.
- EVAL: position index j is issued from 0 up to nerr-1.
  - X_j = alpha^pos_j, Xinv = alpha^((SYMB_NUM-1-pos_j) mod (SYMB_NUM-1)).
  - num = Omega(Xinv).
  - den = Lambda'(Xinv) = sum over odd i of lambda_i * Xinv^(i-1).
  - e_j = num * gf_inv(den); if FCR=0, additionally multiply by X_j.
  - Pipeline: index issue -> Xinv reg -> [eval reg if EVAL_PIPE] -> output reg.
  - Latency from EVAL entry to first err_vld: 2 + EVAL_PIPE cycles.
  - Throughput: one beat per cycle while err_rdy=1.
- Handshake:
  - A beat transfers when err_vld & err_rdy.
  - While err_vld=1 & err_rdy=0: err_pos, err_val, err_vld and err_last hold stable and the pipe stalls; no beat is dropped or duplicated.
  - err_last=1 only on beat nerr-1.
- den==0 for any position: forney_fail is set sticky for the block; that beat is still emitted with err_val=0.
- DONE: held for one cycle; forney_done=1 with forney_fail, then -> IDLE. forney_done is asserted in the cycle after the last beat transfers.
- Simultaneous events and ordering:
  - error_positions_vld in IDLE is ignored.
  - error_locator_vld in WAIT_POS, EVAL or DONE aborts the current block: pipe flushed, err_vld deasserted the next cycle, no forney_done for the aborted block; the new polynomials are captured and the FSM enters WAIT_POS.
  - error_locator_vld and error_positions_vld in the same cycle in WAIT_POS: abort/recapture wins; the positions are discarded.
- Reset mid-operation: immediate return to the reset state; no partial output is held.
- Arithmetic: all arithmetic is GF(2^SYMB_WIDTH) using the gf_pkg mult/inv/alpha_to_symb functions. Position exponents are computed modulo SYMB_NUM-1 at SYMB_WIDTH+1 bits.

Optional Feature:
- RS_FORNEY_ROOT_CHECK_EN defined:
  - Each issued position also evaluates Lambda(Xinv).
  - A nonzero result sets forney_fail (sticky for the block); beats are still emitted.
  - Adds one evaluator instance.
- Undefined: no root check; Lambda(Xinv) is not computed.

Decomposition:
- gf_pkg (shared) gains:
  - constant FCR_DEFAULT;
  - typedef forney_state_t {IDLE, WAIT_POS, EVAL, DONE};
  - function gf_poly_deriv_odd, which masks the even coefficients.
- One natural sub-module: rs_forney_eval.
  - Horner-evaluates one polynomial of configurable length at a given symbol.
  - Instantiated for Omega, for Lambda', and for Lambda under the macro.

Test Plan:
- Single error, FCR=1: Lambda={1,alpha^5}, Omega={0x3A*alpha^5}, positions[0]=5, err_rdy=1 -> one beat: err_pos=5, err_val=0x3A, err_last=1; then forney_done=1, forney_fail=0.
- Three random errors at positions {3,17,200} with magnitudes {0x01,0x80,0xFF}, err_rdy toggling 1010 -> three beats in order, values exact, stable while stalled, err_last only on the third.
- rs_chien_err=1 with error_positions_vld -> no err_vld; forney_done=1 and forney_fail=1 on the next cycle.
- Lambda={1,0,...}, so nerr=0 -> no beats; forney_done=1, forney_fail=0.
- New error_locator_vld arrives during the second beat of a 3-error block -> err_vld drops next cycle, no forney_done; the following block completes correctly.
- RS_FORNEY_ROOT_CHECK_EN, positions[0]=6 but the actual root is 5 -> beat emitted; forney_done with forney_fail=1.
